multi_chan_width_cache: RTL and testbench

//  Per-sensor cache between the ADC acquisition front end and the framing/uplink reader.

---
 rtl/cache_pkg.sv | 19 +
 rtl/cache_chan_fifo.sv | 142 ++++++++++++++
 rtl/multi_chan_width_cache.sv | 106 ++++++++++
 tb/tb_multi_chan_width_cache.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared sizing helpers for the multi-channel width-converting sensor cache.
// The optional drop counter (CACHE_DROP_CNT_EN) does not change anything in this package.
package cache_pkg;

  localparam int CNT_PORT_W = 16;

  function automatic int calc_ratio(input int din_w, input int dout_w);
    return din_w / dout_w;
  endfunction

  function automatic int calc_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int calc_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cache_chan_fifo.sv
// Single-channel circular buffer with DIN_W->DOUT_W down-conversion, flags and sticky overflow.
// CACHE_DROP_CNT_EN adds a saturating per-channel drop counter output.
module cache_chan_fifo
  import cache_pkg::*;
#(
  parameter int DIN_W    = 16,
  parameter int DOUT_W   = 8,
  parameter int DEPTH    = 2048,
  parameter int PFULL_TH = 1792
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [DIN_W-1:0]      wr_din_i,
  input  logic                  rd_en_i,
  input  logic                  clr_overflow_i,
  output logic                  wr_acc_o,
  output logic [DOUT_W-1:0]     rd_dout_o,
  output logic                  empty_o,
  output logic                  prog_full_o,
  output logic                  overflow_o,
  output logic [CNT_PORT_W-1:0] rd_data_count_o
`ifdef CACHE_DROP_CNT_EN
  ,
  output logic [CNT_PORT_W-1:0] drop_cnt_o
`endif
);

  localparam int RATIO = calc_ratio(DIN_W, DOUT_W);
  localparam int CNT_W = calc_cnt_w(DEPTH);
  localparam int AW    = calc_ptr_w(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(RATIO);
  localparam logic [CNT_W-1:0] PFULL_C = CNT_W'(PFULL_TH);

  logic [DOUT_W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, free_s;
  logic                  rd_do_s, drop_s, ovf_d;
  logic [CNT_PORT_W-1:0] cnt_port_s;

  // Accept only whole words; a same-cycle read never frees room for the write.
  always_comb begin
    free_s   = DEPTH_C - cnt_q;
    wr_acc_o = wr_en_i && (free_s >= RATIO_C);
    drop_s   = wr_en_i && !wr_acc_o;
    rd_do_s  = rd_en_i && !empty_o;
    if (wr_acc_o) begin
      wr_ptr_d = wr_ptr_q + AW'(RATIO);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_do_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_acc_o, rd_do_s})
      2'b10:   cnt_d = cnt_q + RATIO_C;
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      2'b11:   cnt_d = cnt_q + RATIO_C - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_overflow_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = overflow_o;
    end
  end

  if (CNT_W > CNT_PORT_W) begin : g_sat
    localparam logic [CNT_W-1:0] PORT_MAX_C = {{(CNT_W-CNT_PORT_W){1'b0}}, {CNT_PORT_W{1'b1}}};
    always_comb begin
      if (cnt_d > PORT_MAX_C) begin
        cnt_port_s = {CNT_PORT_W{1'b1}};
      end else begin
        cnt_port_s = cnt_d[CNT_PORT_W-1:0];
      end
    end
  end else begin : g_ext
    assign cnt_port_s = CNT_PORT_W'(cnt_d);
  end

  // Most-significant slice lands at the lowest address so it is read first.
  always_ff @(posedge clk_i) begin
    if (wr_acc_o) begin
      for (int k = 0; k < RATIO; k++) begin
        mem_q[wr_ptr_q + AW'(k)] <= wr_din_i[(RATIO-1-k)*DOUT_W +: DOUT_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      cnt_q           <= '0;
      empty_o         <= 1'b1;
      prog_full_o     <= 1'b0;
      overflow_o      <= 1'b0;
      rd_data_count_o <= '0;
      rd_dout_o       <= '0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      cnt_q           <= cnt_d;
      empty_o         <= (cnt_d == '0);
      prog_full_o     <= (cnt_d >= PFULL_C);
      overflow_o      <= ovf_d;
      rd_data_count_o <= cnt_port_s;
      if (rd_do_s) begin
        rd_dout_o <= mem_q[rd_ptr_q];
      end
    end
  end

`ifdef CACHE_DROP_CNT_EN
  logic [CNT_PORT_W-1:0] drop_cnt_d;

  // A clear coinciding with a drop restarts the count at one.
  always_comb begin
    if (clr_overflow_i) begin
      drop_cnt_d = drop_s ? CNT_PORT_W'(1) : CNT_PORT_W'(0);
    end else if (drop_s && (drop_cnt_o != {CNT_PORT_W{1'b1}})) begin
      drop_cnt_d = drop_cnt_o + CNT_PORT_W'(1);
    end else begin
      drop_cnt_d = drop_cnt_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      drop_cnt_o <= '0;
    end else begin
      drop_cnt_o <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: rtl/multi_chan_width_cache.sv
// N-channel sensor cache: reset/sim-mode synchronisers, seeded sim counters, input staging.
// CACHE_DROP_CNT_EN exposes drop_cnt_o (per-channel saturating dropped-write count).
module multi_chan_width_cache
  import cache_pkg::*;
#(
  parameter int SENSOR_NUM = 20,
  parameter int DIN_W      = 16,
  parameter int DOUT_W     = 8,
  parameter int DEPTH      = 2048,
  parameter int PFULL_TH   = 1792
) (
  input  logic                             sys_clk_i,
  input  logic                             rst_n_i,
  input  logic [SENSOR_NUM-1:0]            wr_en_i,
  input  logic [SENSOR_NUM*DIN_W-1:0]      wr_din_i,
  input  logic                             adc_acq_start_pluse_i,
  input  logic                             sim_data_en_i,
  input  logic                             clr_overflow_i,
  input  logic [SENSOR_NUM-1:0]            rd_en_i,
  output logic [SENSOR_NUM*DOUT_W-1:0]     rd_dout_o,
  output logic [SENSOR_NUM-1:0]            empty_o,
  output logic [SENSOR_NUM-1:0]            prog_full_o,
  output logic [SENSOR_NUM-1:0]            overflow_o,
  output logic [SENSOR_NUM*CNT_PORT_W-1:0] rd_data_count_o
`ifdef CACHE_DROP_CNT_EN
  ,
  output logic [SENSOR_NUM*CNT_PORT_W-1:0] drop_cnt_o
`endif
);

  localparam int RATIO = calc_ratio(DIN_W, DOUT_W);

  logic [1:0]                  rst_sync_q;
  logic                        rst_n_s;
  logic                        sim_meta_q, sim_q, stg_sim_q;
  logic [SENSOR_NUM-1:0]       stg_wr_q;
  logic [SENSOR_NUM*DIN_W-1:0] stg_din_q;

  // Reset asserts asynchronously and releases on a clock edge.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_q[1];

  always_ff @(posedge sys_clk_i or negedge rst_n_s) begin
    if (!rst_n_s) begin
      sim_meta_q <= 1'b0;
      sim_q      <= 1'b0;
      stg_sim_q  <= 1'b0;
      stg_wr_q   <= '0;
      stg_din_q  <= '0;
    end else begin
      sim_meta_q <= sim_data_en_i;
      sim_q      <= sim_meta_q;
      stg_sim_q  <= sim_q;
      stg_wr_q   <= sim_q ? {SENSOR_NUM{adc_acq_start_pluse_i}} : wr_en_i;
      stg_din_q  <= wr_din_i;
    end
  end

  for (genvar i = 0; i < SENSOR_NUM; i++) begin : g_ch
    logic [DOUT_W-1:0] simcnt_q;
    logic [DIN_W-1:0]  fifo_din_s;
    logic              wr_acc_s;

    // Sim data is formed at store time so back-to-back pulses see the advanced counter.
    assign fifo_din_s = stg_sim_q ? {RATIO{simcnt_q}} : stg_din_q[i*DIN_W +: DIN_W];

    always_ff @(posedge sys_clk_i or negedge rst_n_s) begin
      if (!rst_n_s) begin
        simcnt_q <= DOUT_W'(i);
      end else if (wr_acc_s && stg_sim_q) begin
        simcnt_q <= simcnt_q + DOUT_W'(1);
      end
    end

    cache_chan_fifo #(
      .DIN_W    (DIN_W),
      .DOUT_W   (DOUT_W),
      .DEPTH    (DEPTH),
      .PFULL_TH (PFULL_TH)
    ) u_fifo (
      .clk_i           (sys_clk_i),
      .rst_n_i         (rst_n_s),
      .wr_en_i         (stg_wr_q[i]),
      .wr_din_i        (fifo_din_s),
      .rd_en_i         (rd_en_i[i]),
      .clr_overflow_i  (clr_overflow_i),
      .wr_acc_o        (wr_acc_s),
      .rd_dout_o       (rd_dout_o[i*DOUT_W +: DOUT_W]),
      .empty_o         (empty_o[i]),
      .prog_full_o     (prog_full_o[i]),
      .overflow_o      (overflow_o[i]),
      .rd_data_count_o (rd_data_count_o[i*CNT_PORT_W +: CNT_PORT_W])
`ifdef CACHE_DROP_CNT_EN
      ,
      .drop_cnt_o      (drop_cnt_o[i*CNT_PORT_W +: CNT_PORT_W])
`endif
    );
  end

endmodule

// File: tb/tb_multi_chan_width_cache.sv
// Directed bench for multi_chan_width_cache; read data goes through an expected-value queue
// checked by a separate monitor. Drop-counter checks run when CACHE_DROP_CNT_EN is defined.
module tb_multi_chan_width_cache;
  localparam int N = 4, DIN_W = 16, DOUT_W = 8, DEPTH = 16, PFULL_TH = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      wr_en, rd_en;
  logic [N*DIN_W-1:0] wr_din;
  logic              adc_pulse, sim_en, clr_ovf;
  logic [N*DOUT_W-1:0] rd_dout;
  logic [N-1:0]      empty, pfull, ovf;
  logic [N*16-1:0]   count;
`ifdef CACHE_DROP_CNT_EN
  logic [N*16-1:0]   drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct { int ch; logic [7:0] d; } exp_t;
  exp_t exp_q[$];
  logic [N-1:0] rd_pend = '0;

  always #5 clk = ~clk;

  multi_chan_width_cache #(
    .SENSOR_NUM(N), .DIN_W(DIN_W), .DOUT_W(DOUT_W), .DEPTH(DEPTH), .PFULL_TH(PFULL_TH)
  ) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_din_i(wr_din),
    .adc_acq_start_pluse_i(adc_pulse), .sim_data_en_i(sim_en), .clr_overflow_i(clr_ovf),
    .rd_en_i(rd_en), .rd_dout_o(rd_dout), .empty_o(empty), .prog_full_o(pfull),
    .overflow_o(ovf), .rd_data_count_o(count)
`ifdef CACHE_DROP_CNT_EN
    , .drop_cnt_o(drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input logic [15:0] d);
    wr_en[ch] = 1'b1;
    wr_din[ch*DIN_W +: DIN_W] = d;
    cyc();
    wr_en[ch] = 1'b0;
  endtask

  task automatic rd(input int ch, input logic [7:0] d);
    exp_t e;
    e.ch = ch;
    e.d  = d;
    exp_q.push_back(e);
    rd_en[ch]   = 1'b1;
    rd_pend[ch] = 1'b1;
    cyc();
    rd_en[ch]   = 1'b0;
    rd_pend[ch] = 1'b0;
  endtask

  function automatic logic [15:0] cnt_of(input int ch);
    return count[ch*16 +: 16];
  endfunction

  // Monitor: one cycle after each expected read, compare dout against the queue head.
  always begin
    logic [N-1:0] pend_s;
    exp_t e;
    @(posedge clk);
    pend_s = rd_pend;
    #1;
    for (int c = 0; c < N; c++) begin
      if (pend_s[c]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_data ch%0d: actual=%0h required=<no entry>", c, rd_dout[c*8 +: 8]);
        end else begin
          e = exp_q.pop_front();
          if (e.ch != c || rd_dout[c*8 +: 8] !== e.d) begin
            errors++;
            $display("FAIL rd_data ch%0d: actual=%0h required=%0h (ch%0d)", c, rd_dout[c*8 +: 8], e.d, e.ch);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b [16];
    rst_n = 1'b0; wr_en = '0; rd_en = '0; wr_din = '0;
    adc_pulse = 1'b0; sim_en = 1'b0; clr_ovf = 1'b0;
    for (int j = 0; j < 16; j++) b[j] = 8'h40 + 8'(j);
    repeat (3) cyc();
    check("reset_empty", 32'(empty), 32'hF);
    check("reset_count", 32'(count), 32'h0);
    rst_n = 1'b1;
    repeat (4) cyc();

    // 1. reset mid-traffic, including a staged write in flight
    wr(0, 16'h1111);
    wr(0, 16'h2222);
    cyc();
    check("pre_reset_cnt0", 32'(cnt_of(0)), 32'd4);
    wr(2, 16'h5555);
    rst_n = 1'b0;
    #1;
    check("async_count", 32'(count), 32'h0);
    check("async_empty", 32'(empty), 32'hF);
    check("async_flags", {16'(pfull), 16'(ovf)}, 32'h0);
    check("async_dout", 32'(rd_dout), 32'h0);
    cyc();
    rst_n = 1'b1;
    repeat (5) cyc();
    check("inflight_lost_cnt2", 32'(cnt_of(2)), 32'd0);

    // 2. ch0 single write, two reads, then read while empty
    wr(0, 16'hA1B2);
    check("latency_cnt0_early", 32'(cnt_of(0)), 32'd0);
    cyc();
    check("cnt0_after_write", 32'(cnt_of(0)), 32'd2);
    check("empty0_after_write", 32'(empty[0]), 32'd0);
    rd(0, 8'hA1);
    rd(0, 8'hB2);
    check("empty0_drained", 32'(empty[0]), 32'd1);
    rd_en[0] = 1'b1;
    cyc();
    rd_en[0] = 1'b0;
    check("empty_read_dout_held", 32'(rd_dout[7:0]), 32'hB2);
    check("empty_read_cnt0", 32'(cnt_of(0)), 32'd0);

    // 3. ch1 fill to full, prog_full threshold, drop, clear
    for (int k = 0; k < 5; k++) wr(1, {b[2*k], b[2*k+1]});
    cyc();
    check("cnt1_10", 32'(cnt_of(1)), 32'd10);
    check("pfull1_below", 32'(pfull[1]), 32'd0);
    wr(1, {b[10], b[11]});
    cyc();
    check("pfull1_at_th", 32'(pfull[1]), 32'd1);
    wr(1, {b[12], b[13]});
    wr(1, {b[14], b[15]});
    cyc();
    check("cnt1_full", 32'(cnt_of(1)), 32'd16);
    check("ovf1_before_drop", 32'(ovf[1]), 32'd0);
    wr(1, 16'hFFFF);
    cyc();
    check("cnt1_after_drop", 32'(cnt_of(1)), 32'd16);
    check("ovf1_after_drop", 32'(ovf[1]), 32'd1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    check("ovf1_cleared", 32'(ovf[1]), 32'd0);

    // 4. count 15: write+read same cycle drops the write
    rd(1, b[0]);
    wr(1, 16'hEEEE);
    rd(1, b[1]);
    check("cnt1_wr_rd_drop", 32'(cnt_of(1)), 32'd14);
    check("ovf1_wr_rd_drop", 32'(ovf[1]), 32'd1);
    wr(1, 16'hC3D4);
    rd(1, b[2]);
    check("cnt1_wr_rd_accept", 32'(cnt_of(1)), 32'd15);
    for (int j = 3; j < 16; j++) rd(1, b[j]);
    rd(1, 8'hC3);
    rd(1, 8'hD4);
    check("empty1_drained", 32'(empty[1]), 32'd1);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;

    // 5. sim pattern: three back-to-back pulses
    sim_en = 1'b1;
    repeat (3) cyc();
    adc_pulse = 1'b1;
    repeat (3) cyc();
    adc_pulse = 1'b0;
    cyc();
    check("sim_cnt0", 32'(cnt_of(0)), 32'd6);
    check("sim_cnt2", 32'(cnt_of(2)), 32'd6);
    for (int j = 0; j < 6; j++) rd(2, 8'h02 + 8'(j / 2));
    for (int j = 0; j < 6; j++) rd(0, 8'h00 + 8'(j / 2));
    sim_en = 1'b0;
    repeat (3) cyc();

    // 6. ch3 (6 sim words): fill, five drops, clear coinciding with a drop
    for (int k = 0; k < 10; k++) wr(3, 16'h3300 + 16'(k));
    cyc();
    check("cnt3_full", 32'(cnt_of(3)), 32'd16);
    check("ovf3_set", 32'(ovf[3]), 32'd1);
`ifdef CACHE_DROP_CNT_EN
    check("drop_cnt3_5", 32'(drop_cnt[3*16 +: 16]), 32'd5);
`endif
    wr(3, 16'h3399);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    check("ovf3_set_wins", 32'(ovf[3]), 32'd1);
`ifdef CACHE_DROP_CNT_EN
    check("drop_cnt3_clr_drop", 32'(drop_cnt[3*16 +: 16]), 32'd1);
`endif
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    check("ovf3_cleared", 32'(ovf[3]), 32'd0);
`ifdef CACHE_DROP_CNT_EN
    check("drop_cnt3_cleared", 32'(drop_cnt[3*16 +: 16]), 32'd0);
`endif

    repeat (2) cyc();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
